// File: rtl/div_clk_monitor_if.sv
// div_clk_monitor_if: divided-clock input and measurement bundle
// for the divider output monitor.
interface div_clk_monitor_if #(
   parameter int CNT_W = 16
);
   logic             div_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             period_err;
   logic             locked;
   logic             stall;

   modport master (
      input  div_in,
      output period,
      output high_time,
      output meas_valid,
      output period_err,
      output locked,
      output stall
   );

   modport slave (
      output div_in,
      input  period,
      input  high_time,
      input  meas_valid,
      input  period_err,
      input  locked,
      input  stall
   );
endinterface

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period/high time of the divided clock,
// flags out-of-tolerance periods, tracks lock and detects stalls.
module div_clk_monitor #(
   parameter int EXP_DIV = 6,
   parameter int TOL     = 0,
   parameter int LOCK_N  = 4,
   parameter int TIMEOUT = 4 * EXP_DIV,
   parameter int CNT_W   = 16
) (
   input  logic clk,
   input  logic reset,
   div_clk_monitor_if.master bus
);

   localparam int XW = CNT_W + 1;
   localparam int GW = $clog2(LOCK_N + 1);
   localparam logic [XW-1:0]    EXP_X  = XW'(EXP_DIV);
   localparam logic [XW-1:0]    TOL_X  = XW'(TOL);
   localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
   localparam logic [GW-1:0]    LOCK_G = GW'(LOCK_N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RUN
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic             r_div_q;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_hi_hold;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high;
   logic [GW-1:0]    r_good;
   logic             r_mv;
   logic             r_perr;
   logic             r_locked;
   logic             r_stall;

   logic             w_rise;
   logic             w_fall;
   logic             w_active;
   logic             w_timeout;
   logic             w_meas;
   logic             w_stall_ev;
   logic [XW-1:0]    w_cnt_x;
   logic [XW-1:0]    w_diff;
   logic             w_bad;
   logic [GW-1:0]    w_good_inc;

   assign w_rise    = bus.div_in & ~r_div_q;
   assign w_fall    = ~bus.div_in & r_div_q;
   assign w_active  = (r_state != S_IDLE);
   assign w_timeout = (r_cnt >= TO_C);

   // Widened so the distance from EXP_DIV never wraps
   assign w_cnt_x = {1'b0, r_cnt};
   assign w_diff  = (w_cnt_x >= EXP_X) ? (w_cnt_x - EXP_X)
                                       : (EXP_X - w_cnt_x);
   assign w_bad   = (w_diff > TOL_X);

   assign w_good_inc = (r_good == LOCK_G) ? r_good
                                          : r_good + GW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A rise coinciding with timeout wins: it is a measurement
   always_comb begin
      w_state_nxt = r_state;
      w_meas      = 1'b0;
      w_stall_ev  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_rise) begin
               w_state_nxt = S_ARMED;
            end
         end
         S_ARMED, S_RUN: begin
            if (w_rise) begin
               w_state_nxt = S_RUN;
               w_meas      = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt = S_IDLE;
               w_stall_ev  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_q   <= 1'b0;
         r_cnt     <= '0;
         r_hi_hold <= '0;
         r_period  <= '0;
         r_high    <= '0;
         r_good    <= '0;
         r_mv      <= 1'b0;
         r_perr    <= 1'b0;
         r_locked  <= 1'b0;
         r_stall   <= 1'b0;
      end else begin
         r_div_q <= bus.div_in;
         r_mv    <= w_meas;

         if (w_rise) begin
            r_cnt <= CNT_W'(1);
         end else if (w_stall_ev) begin
            r_cnt <= '0;
         end else if (w_active && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         // Cleared on rise so a period without a fall reports 0
         if (w_rise) begin
            r_hi_hold <= '0;
         end else if (w_fall && w_active) begin
            r_hi_hold <= r_cnt;
         end

         if (w_meas) begin
            r_period <= r_cnt;
            r_high   <= r_hi_hold;
            r_perr   <= w_bad;
            if (w_bad) begin
               r_good   <= '0;
               r_locked <= 1'b0;
            end else begin
               r_good   <= w_good_inc;
               r_locked <= (w_good_inc == LOCK_G);
            end
         end

         if (w_stall_ev) begin
            r_stall  <= 1'b1;
            r_good   <= '0;
            r_locked <= 1'b0;
         end else if (w_rise) begin
            r_stall <= 1'b0;
         end
      end
   end

   assign bus.period     = r_period;
   assign bus.high_time  = r_high;
   assign bus.meas_valid = r_mv;
   assign bus.period_err = r_perr;
   assign bus.locked     = r_locked;
   assign bus.stall      = r_stall;

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: table vectors, directed corner sequences and
// random waveforms checked against a time-stamp reference model.
module tb_div_clk_monitor;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   div_clk_monitor_if #(.CNT_W(16)) bus_a ();
   div_clk_monitor_if #(.CNT_W(16)) bus_b ();

   div_clk_monitor #(
      .EXP_DIV(6), .TOL(0), .LOCK_N(4), .TIMEOUT(24), .CNT_W(16)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.master)
   );

   div_clk_monitor #(
      .EXP_DIV(6), .TOL(1), .LOCK_N(4), .TIMEOUT(24), .CNT_W(16)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.master)
   );

   // Model keeps timestamps of edges, not counters
   typedef struct {
      bit armed; int lr; int lf; bit fs; int good; bit prev;
      int per; int hi; bit mv; bit err; bit lck; bit stl;
   } mdl_t;

   typedef struct {
      int hi; int lo; int per; int hig;
      bit err0; bit err1; bit lck;
   } vec_t;

   typedef struct {
      int per; int hig; bit err0; bit err1; bit lck;
   } cap_t;

   int   errs = 0;
   int   checks = 0;
   int   cyc = 0;
   mdl_t ma, mb;
   bit   prev_mv = 0;
   bit   cap_en = 0;
   cap_t cap_q[$];

   function automatic mdl_t mstep(mdl_t m, bit din, bit rst,
                                  int tol, int t);
      mdl_t n;
      bit rise, fall;
      int p, d;
      n = m;
      if (rst) begin
         n = '{default: 0};
         return n;
      end
      rise = din && !m.prev;
      fall = !din && m.prev;
      n.prev = din;
      n.mv = 0;
      if (rise) begin
         if (m.armed) begin
            p = t - m.lr;
            d = (p > 6) ? p - 6 : 6 - p;
            n.per = p;
            n.hi = m.fs ? (m.lf - m.lr) : 0;
            n.mv = 1;
            n.err = (d > tol);
            n.good = n.err ? 0 : ((m.good < 4) ? m.good + 1 : 4);
            n.lck = (n.good == 4);
         end else begin
            n.armed = 1;
            n.stl = 0;
         end
         n.lr = t;
         n.fs = 0;
      end else begin
         if (fall && m.armed) begin
            n.lf = t;
            n.fs = 1;
         end
         if (m.armed && (t - m.lr >= 24)) begin
            n.stl = 1;
            n.good = 0;
            n.lck = 0;
            n.armed = 0;
         end
      end
      return n;
   endfunction

   task automatic chk_m(input string nm, input mdl_t m,
                        input logic [15:0] per, input logic [15:0] hi,
                        input logic mv, input logic err,
                        input logic lck, input logic stl);
      checks++;
      if (int'(per) != m.per || int'(hi) != m.hi || mv !== m.mv ||
          err !== m.err || lck !== m.lck || stl !== m.stl) begin
         errs++;
         $display("FAIL %s cyc=%0d got per=%0d hi=%0d mv=%b err=%b lck=%b stl=%b exp per=%0d hi=%0d mv=%b err=%b lck=%b stl=%b",
                  nm, cyc, per, hi, mv, err, lck, stl,
                  m.per, m.hi, m.mv, m.err, m.lck, m.stl);
      end
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
      end
   endtask

   task automatic tick(input bit din, input bit rst);
      cap_t c;
      bus_a.div_in = din;
      bus_b.div_in = din;
      reset = rst;
      @(posedge clk);
      cyc++;
      ma = mstep(ma, din, rst, 0, cyc);
      mb = mstep(mb, din, rst, 1, cyc);
      #1;
      chk_m("model_a", ma, bus_a.period, bus_a.high_time,
            bus_a.meas_valid, bus_a.period_err, bus_a.locked,
            bus_a.stall);
      chk_m("model_b", mb, bus_b.period, bus_b.high_time,
            bus_b.meas_valid, bus_b.period_err, bus_b.locked,
            bus_b.stall);
      if (bus_a.meas_valid) begin
         chk("no_back_to_back", int'(prev_mv), 0);
         if (cap_en) begin
            c.per  = int'(bus_a.period);
            c.hig  = int'(bus_a.high_time);
            c.err0 = bus_a.period_err;
            c.err1 = bus_b.period_err;
            c.lck  = bus_a.locked;
            cap_q.push_back(c);
         end
      end
      prev_mv = bus_a.meas_valid;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_per"}, int'(bus_a.period), 0);
      chk({nm, "_hi"}, int'(bus_a.high_time), 0);
      chk({nm, "_flags"},
          int'({bus_a.meas_valid, bus_a.period_err,
                bus_a.locked, bus_a.stall}), 0);
   endtask

   task automatic wave(input int hi, input int lo);
      repeat (hi) tick(1'b1, 1'b0);
      repeat (lo) tick(1'b0, 1'b0);
   endtask

   vec_t tbl[$];

   initial begin
      int rc, sc, nmv;
      ma = '{default: 0};
      mb = '{default: 0};
      reset = 1'b1;
      bus_a.div_in = 1'b0;
      bus_b.div_in = 1'b0;

      tick(0, 1);
      tick(0, 1);
      chk_zero("reset_state");

      // Nominal lock, bad period, relock, tolerance, toggling
      repeat (5) tbl.push_back('{3, 3, 6, 3, 0, 0, 0});
      tbl[3].lck = 1;
      tbl[4].lck = 1;
      tbl.push_back('{5, 3, 8, 5, 1, 1, 0});
      repeat (3) tbl.push_back('{3, 3, 6, 3, 0, 0, 0});
      tbl.push_back('{3, 3, 6, 3, 0, 0, 1});
      tbl.push_back('{3, 2, 5, 3, 1, 0, 0});
      tbl.push_back('{4, 3, 7, 4, 1, 0, 0});
      tbl.push_back('{3, 3, 6, 3, 0, 0, 0});
      tbl.push_back('{2, 2, 4, 2, 1, 1, 0});
      repeat (3) tbl.push_back('{1, 1, 2, 1, 1, 1, 0});

      cap_q.delete();
      cap_en = 1;
      foreach (tbl[i]) wave(tbl[i].hi, tbl[i].lo);
      tick(1, 0);
      cap_en = 0;
      chk("tbl_count", cap_q.size(), tbl.size());
      for (int i = 0; i < tbl.size() && i < cap_q.size(); i++) begin
         chk($sformatf("tbl%0d_per", i), cap_q[i].per, tbl[i].per);
         chk($sformatf("tbl%0d_hi", i), cap_q[i].hig, tbl[i].hig);
         chk($sformatf("tbl%0d_err0", i),
             int'(cap_q[i].err0), int'(tbl[i].err0));
         chk($sformatf("tbl%0d_err1", i),
             int'(cap_q[i].err1), int'(tbl[i].err1));
         chk($sformatf("tbl%0d_lck", i),
             int'(cap_q[i].lck), int'(tbl[i].lck));
      end

      // Stall: last rise was the trailing tick above
      rc = cyc;
      sc = -1;
      for (int k = 0; k < 40 && sc < 0; k++) begin
         tick(0, 0);
         if (bus_a.stall) sc = cyc;
      end
      chk("stall_delay", sc - rc, 24);
      chk("stall_unlock", int'(bus_a.locked), 0);
      tick(1, 0);
      chk("rearm_no_mv", int'(bus_a.meas_valid), 0);
      chk("rearm_clr_stall", int'(bus_a.stall), 0);
      tick(1, 0);
      repeat (4) tick(0, 0);
      tick(1, 0);
      chk("rearm_mv", int'(bus_a.meas_valid), 1);
      chk("rearm_per", int'(bus_a.period), 6);
      chk("rearm_hi", int'(bus_a.high_time), 2);
      tick(1, 0);
      tick(0, 0);
      tick(0, 0);

      // Reset mid-high while locked
      repeat (5) wave(3, 3);
      chk("pre_reset_lock", int'(bus_a.locked), 1);
      tick(1, 0);
      tick(1, 1);
      chk_zero("mid_reset");
      nmv = 0;
      repeat (3) begin
         tick(1, 0);
         nmv += int'(bus_a.meas_valid);
      end
      repeat (3) begin
         tick(0, 0);
         nmv += int'(bus_a.meas_valid);
      end
      chk("post_reset_quiet", nmv, 0);
      tick(1, 0);
      chk("post_reset_mv", int'(bus_a.meas_valid), 1);
      chk("post_reset_per", int'(bus_a.period), 6);

      // Held high from reset: one rise, then stall
      tick(1, 1);
      rc = -1;
      sc = -1;
      nmv = 0;
      for (int k = 0; k < 40; k++) begin
         tick(1, 0);
         if (rc < 0) rc = cyc;
         nmv += int'(bus_a.meas_valid);
         if (bus_a.stall && sc < 0) sc = cyc;
      end
      chk("held_high_no_mv", nmv, 0);
      chk("held_high_stall", sc - rc, 24);

      // Random waveforms with occasional long lows and resets
      for (int s = 0; s < 400; s++) begin
         int hi, lo;
         hi = int'($urandom_range(1, 8));
         lo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 30))
                                          : int'($urandom_range(1, 9));
         if ($urandom_range(0, 49) == 0) begin
            repeat (hi) tick(1, 0);
            tick($urandom_range(0, 1) == 1, 1);
            repeat (lo) tick(0, 0);
         end else begin
            wave(hi, lo);
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Measures the divided-clock output of the clock-divider stage in units of the fast `clk`, reporting period and high time for every cycle of the divided signal. It flags periods outside tolerance, declares lock after a run of good periods, and detects a stalled divider output. The block sits directly downstream of the divider. It samples the divided clock as ordinary data on `clk`; the divider output is already synchronous to `clk`, so no synchronizer is used.

## Interface
- `EXP_DIV`, default 6: expected divided period in `clk` cycles.
- `TOL`, default 0: allowed |period − `EXP_DIV`| for a good measurement.
- `LOCK_N`, default 4: consecutive good periods required for lock.
- `TIMEOUT`, default 4*`EXP_DIV`: `clk` cycles without a rising edge before stall.
- `CNT_W`, default 16: width of the counter and measurement outputs; must hold `TIMEOUT`.

- `clk`  in  1  fast clock. Clock is `clk`.
- `reset`  in  1  reset, synchronous, active-high.
- `div_in`  in  1  divided clock from the divider stage, synchronous to `clk`.
- `period`  out  CNT_W  last measured rise-to-rise period in `clk` cycles.
- `high_time`  out  CNT_W  last measured rise-to-fall time in `clk` cycles.
- `meas_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `period_err`  out  1  last period was out of tolerance; qualified by `meas_valid`, held until the next update.
- `locked`  out  1  `LOCK_N` consecutive good periods seen.
- `stall`  out  1  sticky timeout flag.

## Operation
- **Edge detection**
  - `div_q` registers `div_in` every cycle; reset value 0.
  - `rise` = `div_in & ~div_q`; `fall` = `~div_in & div_q`. Both are combinational.
- **Counter `cnt`**
  - `rise` loads 1.
  - In states ARMED and RUN, every other cycle increments `cnt`, saturating at 2^CNT_W−1.
  - In IDLE, `cnt` holds at 0.
- **FSM**
  - IDLE → ARMED on the first `rise`. This edge produces no measurement.
  - ARMED → RUN on the next `rise`, which produces the first measurement.
  - RUN → RUN on each `rise`, with a measurement each time.
  - ARMED or RUN → IDLE on a stall event.
- **Measurement** on `rise` in ARMED or RUN:
  - `period` ← `cnt`.
  - `meas_valid` ← 1.
  - `period_err` ← (|`cnt` − `EXP_DIV`| > `TOL`).
- **High time:** `fall` in ARMED or RUN sets `hi_hold` ← `cnt`. `high_time` ← `hi_hold` with each measurement.
  - `fall` in IDLE is ignored.
  - If no `fall` occurred since the previous `rise`, `high_time` is reported as 0.
- **Lock counter `good_cnt`**, range 0..`LOCK_N`:
  - A good measurement increments `good_cnt`, saturating at `LOCK_N`.
  - A bad measurement clears `good_cnt` to 0.
  - `locked` = (`good_cnt` == `LOCK_N`), registered.
  - `locked` deasserts in the same cycle as the `meas_valid` of the first bad measurement.
- **Stall event:** condition is `~rise && cnt >= TIMEOUT && state != IDLE`.
  - Effects: `stall` ← 1, `good_cnt` ← 0, `locked` ← 0, state ← IDLE.
  - `stall` clears on the next `rise`, which also re-arms the FSM (IDLE → ARMED).
- **Simultaneous events:** `rise` and the timeout condition in the same cycle resolve as a measurement, not a stall. The measured period is ≥ `TIMEOUT`, so `period_err` is normally 1.
- **Arithmetic:** the tolerance compare is unsigned, using width CNT_W+1 to avoid wrap.

## Timing
- **Reset values:** state=IDLE; `div_q`, `cnt`, `good_cnt`, `hi_hold`, `period`, `high_time`, `meas_valid`, `period_err`, `locked`, `stall` are all 0.
- **Latency:**
  - `div_in` first seen high at cycle t (`rise` at t) → `meas_valid`, `period`, `high_time`, `period_err`, `locked` visible at t+1.
  - Stall event at cycle t → `stall`=1 and `locked`=0 visible at t+1.
- **Measurement rate:** `meas_valid` is never high in two consecutive cycles. The minimum period is 2.
- **Reset mid-measurement:** everything returns to reset values on the next edge. A partial period is discarded, with no `meas_valid`.

## Test plan
- **Nominal lock:** `div_in` = DIV-6 waveform (3 high, 3 low) after reset; `EXP_DIV`=6, `TOL`=0, `LOCK_N`=4.
  - First `meas_valid` one cycle after the 2nd rise, with `period`=6, `high_time`=3, `period_err`=0.
  - `locked`=1 with the 4th `meas_valid`, i.e. after the 5th rise.
- **Bad period:** locked on DIV-6, then one period of 8 (5 high, 3 low).
  - `meas_valid` with `period`=8, `high_time`=5, `period_err`=1, `locked`=0 in the same cycle.
  - Relock after 4 further good periods.
- **Tolerance:** `TOL`=1; periods of 5 and 7 give `period_err`=0; a period of 4 gives `period_err`=1.
- **Stall:** in RUN, hold `div_in` low.
  - `stall`=1 and `locked`=0 one cycle after `cnt` reaches 24.
  - Next rise clears `stall` with no `meas_valid`; the following rise gives `meas_valid`.
- **Reset mid-operation:** assert `reset` for 1 cycle mid-high-phase while locked.
  - All outputs are 0 next cycle.
  - First `meas_valid` appears only after two new rises.
- **Edge cases:**
  - `div_in` toggling every cycle gives `period`=2, `high_time`=1, and no back-to-back `meas_valid`.
  - `div_in` held high from reset gives one `rise` only, and `stall` after `TIMEOUT` cycles.
